// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: seven-segment patterns, anode constants and slot classification shared by display blocks
package seg_scan_decoder_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] AN_IDLE    = 4'b1111;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_GOOD, SLOT_BAD} slot_e;

  // idle when no anode is low, good when exactly one is, bad otherwise
  function automatic slot_e classify(input logic [3:0] an);
    if (an == AN_IDLE) return SLOT_IDLE;
    if ($countones(~an) == 1) return SLOT_GOOD;
    return SLOT_BAD;
  endfunction

  // index of the lowest active (low) anode
  function automatic logic [1:0] low_idx(input logic [3:0] an);
    return !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/seg_scan_decoder_decode.sv
// seg_pattern_decode: active-low seven-segment pattern to BCD code with legality flag
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_legal
);
  // table lookup; anything outside the digit set or blank is illegal
  always_comb begin
    o_code  = 4'h0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_BLANK: o_code = BLANK_CODE;
      default:   o_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reconstructs four multiplexed seven-segment digits from the display bus
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int BoardFreq     = 100_000_000,
  parameter int SettleCycles  = 16,
  parameter int TimeoutCycles = BoardFreq / 100,
  parameter int CntBits       = 20
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [6:0]  Seg,
  input  logic [3:0]  an,
  output logic [15:0] Digits,
  output logic [3:0]  Valid,
  output logic        Frame,
  output logic        Err,
  output logic        Stale
);
  localparam logic [7:0]         SET_MAX = 8'(SettleCycles);
  localparam logic [7:0]         SET_CAP = 8'(SettleCycles - 2);
  localparam logic [CntBits-1:0] TO_MAX  = CntBits'(TimeoutCycles);

  logic [10:0]        r_sync1, r_sync2, r_prev;
  logic [7:0]         r_set;
  logic [CntBits-1:0] r_to;
  logic [3:0]         r_seen;
  logic [3:0]         w_an, w_code, w_bit, w_seen_base;
  logic [6:0]         w_seg;
  logic [1:0]         w_idx;
  logic               w_legal, w_match, w_cap, w_good, w_bad_seg, w_err, w_expire;
  slot_e              w_kind;

  assign w_an        = r_sync2[10:7];
  assign w_seg       = r_sync2[6:0];
  assign w_match     = r_sync2 == r_prev;
  assign w_cap       = w_match && r_set == SET_CAP;
  assign w_kind      = classify(w_an);
  assign w_idx       = low_idx(w_an);
  assign w_bit       = 4'b0001 << w_idx;
  assign w_good      = w_cap && w_kind == SLOT_GOOD && w_legal;
  assign w_bad_seg   = w_cap && w_kind == SLOT_GOOD && !w_legal;
  assign w_err       = w_bad_seg || (w_cap && w_kind == SLOT_BAD);
  assign w_expire    = !w_good && r_to == TO_MAX - 1'b1;
  assign w_seen_base = r_seen == 4'hF ? 4'h0 : r_seen;

  seg_pattern_decode u_dec (
    .i_seg   (w_seg),
    .o_code  (w_code),
    .o_legal (w_legal)
  );

  // two-flop synchroniser, last-sample register and saturating settle counter
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_set   <= '0;
    end else begin
      r_sync1 <= {an, Seg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_set   <= !w_match ? 8'd0 : r_set == SET_MAX ? r_set : r_set + 8'd1;
    end
  end

  // capture handling, frame tracking and stale-display timeout
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      Digits <= '0;
      Valid  <= '0;
      Frame  <= 1'b0;
      Err    <= 1'b0;
      Stale  <= 1'b0;
      r_to   <= '0;
      r_seen <= '0;
    end else begin
      Frame <= r_seen == 4'hF;
      Err   <= w_err;
      r_to  <= w_good ? '0 : r_to == TO_MAX ? r_to : r_to + 1'b1;
      if (w_good) begin
        Digits[{w_idx, 2'b00} +: 4] <= w_code;
        Valid  <= Valid | w_bit;
        Stale  <= 1'b0;
        r_seen <= w_seen_base | w_bit;
      end else if (w_expire) begin
        Stale  <= 1'b1;
        Valid  <= '0;
        r_seen <= '0;
      end else begin
        if (w_bad_seg) Valid <= Valid & ~w_bit;
        r_seen <= w_seen_base;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scoreboard bench for the seven-segment scan decoder
module tb_seg_scan_decoder;
  localparam int S = 16;
  localparam int T = 1000;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [6:0]  Seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] Digits;
  logic [3:0]  Valid;
  logic        Frame, Err, Stale;

  seg_scan_decoder #(
    .SettleCycles  (S),
    .TimeoutCycles (T),
    .CntBits       (10)
  ) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .Seg    (Seg),
    .an     (an),
    .Digits (Digits),
    .Valid  (Valid),
    .Frame  (Frame),
    .Err    (Err),
    .Stale  (Stale)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic        e;
    logic        st;
  } exp_t;

  exp_t        q[$];
  int          total = 0, passed = 0, fails = 0, frames = 0, errs = 0;
  int          f0, e0;
  logic [15:0] m_d = '0;
  logic [3:0]  m_v = '0;
  logic        m_st = 1'b0;

  always @(negedge Clk) begin
    if (Frame) frames++;
    if (Err) errs++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      7'b1111111: return {1'b1, 4'hF};
      default:    return {1'b0, 4'h0};
    endcase
  endfunction

  // called at a negedge; hold must be at least S+3 so it returns at a negedge
  task automatic slot(input logic [3:0] a, input logic [6:0] s, input int hold);
    exp_t e;
    logic [4:0] r;
    int n, i;
    e.e = 1'b0;
    n = 0;
    i = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) begin n++; i = k; end
    if (n == 1) begin
      r = ref_dec(s);
      if (r[4]) begin
        m_d[i*4 +: 4] = r[3:0];
        m_v[i] = 1'b1;
        m_st = 1'b0;
      end else begin
        m_v[i] = 1'b0;
        e.e = 1'b1;
      end
    end else if (n > 1) e.e = 1'b1;
    e.d = m_d;
    e.v = m_v;
    e.st = m_st;
    q.push_back(e);
    an = a;
    Seg = s;
    repeat (S + 1) @(posedge Clk);
    #1 chk("err_early", Err, 0);
    @(posedge Clk);
    #1 e = q.pop_front();
    chk("digits", Digits, e.d);
    chk("valid", Valid, e.v);
    chk("err", Err, e.e);
    chk("stale", Stale, e.st);
    repeat (hold - S - 2) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    an = 4'hF;
    Seg = 7'h7F;
    Clr = 1'b1;
    m_d = '0;
    m_v = '0;
    m_st = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_digits", Digits, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_frame", Frame, 0);
    chk("rst_err", Err, 0);
    chk("rst_stale", Stale, 0);
    Clr = 1'b0;
    f0 = frames;
    slot(4'b1110, 7'b0110000, 50);
    slot(4'b1101, 7'b1111001, 50);
    slot(4'b1011, 7'b0000000, 50);
    slot(4'b0111, 7'b1111111, 50);
    chk("scan_frame", frames - f0, 1);
    chk("scan_digits", Digits, 16'hF813);
    chk("scan_valid", Valid, 4'b1111);
    e0 = errs;
    an = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      Seg = k[0] ? 7'b0100100 : 7'b1111001;
      repeat (10) @(negedge Clk);
    end
    chk("glitch_err", errs - e0, 0);
    chk("glitch_digits", Digits, 16'hF813);
    chk("glitch_valid", Valid, 4'b1111);
    slot(4'b1100, 7'b0110000, 30);
    chk("multi_an_err", errs - e0, 1);
    slot(4'b1110, 7'b0101010, 30);
    chk("bad_seg_err", errs - e0, 2);
    chk("bad_seg_valid", Valid, 4'b1110);
    an = 4'b1101;
    Seg = 7'b0100100;
    repeat (5) @(negedge Clk);
    #2 Clr = 1'b1;
    #1 chk("async_digits", Digits, 0);
    chk("async_valid", Valid, 0);
    chk("async_stale", Stale, 0);
    do_reset();
    slot(4'b1110, 7'b0011001, S + 3);
    slot(4'b1101, 7'b0010010, S + 3);
    do_reset();
    f0 = frames;
    slot(4'b1110, 7'b0000010, S + 3);
    slot(4'b1101, 7'b1111000, S + 3);
    slot(4'b1011, 7'b0010000, S + 3);
    repeat (3) @(negedge Clk);
    chk("midclr_noframe", frames - f0, 0);
    slot(4'b0111, 7'b1000000, S + 3);
    repeat (2) @(negedge Clk);
    chk("midclr_frame", frames - f0, 1);
    f0 = frames;
    for (int f = 0; f < 3; f++) begin
      slot(4'b1110, f[0] ? 7'b0011001 : 7'b0110000, S + 3);
      slot(4'b1101, f[1] ? 7'b0000010 : 7'b0100100, S + 3);
      slot(4'b1011, f[0] ? 7'b1111000 : 7'b0010000, S + 3);
      slot(4'b0111, f[1] ? 7'b1000000 : 7'b0010010, S + 3);
    end
    slot(4'b1110, 7'b1111001, S + 3);
    slot(4'b1101, 7'b0000000, S + 3);
    slot(4'b1011, 7'b0110000, S + 3);
    repeat (2) @(negedge Clk);
    chk("b2b_frames", frames - f0, 3);
    slot(4'b0111, 7'b0011001, S + 3);
    repeat (2) @(negedge Clk);
    chk("b2b_next_frame", frames - f0, 4);
    slot(4'b1110, 7'b0010010, S + 3);
    slot(4'b1101, 7'b0000010, S + 3);
    slot(4'b1011, 7'b1111000, S + 3);
    slot(4'b0111, 7'b0000000, S + 3);
    an = 4'hF;
    Seg = 7'h7F;
    repeat (T - 1) @(posedge Clk);
    #1 chk("pre_timeout_stale", Stale, 0);
    chk("pre_timeout_valid", Valid, 4'b1111);
    @(posedge Clk);
    #1 chk("timeout_stale", Stale, 1);
    chk("timeout_valid", Valid, 0);
    chk("timeout_digits", Digits, m_d);
    m_st = 1'b1;
    m_v = '0;
    @(negedge Clk);
    slot(4'b1011, 7'b0010010, 50);
    chk("recover_stale", Stale, 0);
    chk("recover_valid", Valid, 4'b0100);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the 4-digit multiplexed seven-segment interface: samples the active-low segment bus and active-low anode strobes driven by a display block, and reconstructs the four displayed digits.
- Used as an on-board self-check / loopback monitor of display drivers and as a bench checker for them; same 100 MHz Clk domain.
- Performs input synchronisation, a settle filter per scan slot, pattern-to-BCD decoding, frame completion and stale-display detection.

Parameters:
- BoardFreq, 100_000_000, Clk frequency in Hz (documentation and TimeoutCycles derivation only).
- SettleCycles, 16, consecutive stable synchronised cycles required before a slot is captured (legal range 2..255).
- TimeoutCycles, 1_000_000, cycles without a successful capture before Stale is asserted (10 ms at 100 MHz).
- CntBits, 20, width of the timeout counter (2^CntBits > TimeoutCycles).

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Clr  input  1  reset, asynchronous, active-high.
- Seg  input  7  segment bus, active-low, bit 0 = segment a … bit 6 = segment g.
- an  input  4  anode strobes, active-low, an[i]=0 selects digit i.
- Digits  output  16  decoded digits, Digits[4i+3:4i] = digit i; 4'hF = blank.
- Valid  output  4  Valid[i]=1 when digit i holds a good capture.
- Frame  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- Err  output  1  one-cycle pulse on a rejected capture.
- Stale  output  1  level, display scan has stopped.

Behaviour:
- Reset (Clr=1, async): Digits=16'h0000, Valid=4'b0000, Frame=0, Err=0, Stale=0; synchroniser stages=all ones (idle bus); settle, timeout counters and seen-mask = 0.
- Sync: 2-flop synchroniser on {an,Seg} (11 bits). All decisions use the second stage.
- Settle: a previous-sample register holds the last synchronised value. A mismatch clears the settle counter to 0; a match increments it, saturating at SettleCycles.
- Capture event: the single cycle in which the counter goes from SettleCycles-2 to SettleCycles-1. Exactly one capture per stable window.
- Latency: inputs stable at the pins at cycle 0 -> Digits/Valid/Err update on the clock edge at cycle 2+SettleCycles.
- Slot classification at capture:
  - an=4'b1111: blanking interval, silently ignored. No state change.
  - Exactly one an bit low: good slot; go to decode.
  - More than one an bit low: Err pulse; no digit change.
- Decode (good slot):
  - Seg 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1111111→4'hF (blank). Each of these writes digit i, sets Valid[i] and sets seen[i].
  - Any other Seg value: Err pulse, Valid[i] cleared, digit i unchanged, seen[i] unchanged.
- Frame:
  - When the seen-mask becomes 4'b1111, Frame pulses on the following cycle and the mask clears in that same cycle.
  - A capture in the Frame-pulse cycle is recorded into the freshly cleared mask.
- Timeout / Stale:
  - The timeout counter clears on every successful decode and otherwise increments, saturating at TimeoutCycles.
  - On reaching TimeoutCycles: Stale=1, Valid=4'b0000, seen-mask cleared. Digits are held.
  - The next successful decode clears Stale in the same edge that sets its Valid bit.
- Simultaneous events: a decode in the cycle the counter would reach TimeoutCycles takes priority; Stale stays 0.
- Clr mid-frame: all state is lost and the first Frame requires four fresh captures.

Decomposition:
- Shared package (also used by the display counter): the ten digit segment constants, the blank pattern 7'b1111111, BLANK_CODE=4'hF, and the anode idle constant 4'b1111.
- One combinational sub-module, seg_pattern_decode: 7-bit Seg in -> 4-bit code plus a legal flag. Everything else lives in seg_scan_decoder.

Test Plan:
- Reset: assert Clr mid-operation -> all outputs 0 immediately, with no Clk edge needed.
- Scan an=1110/Seg=0110000, 1101/1111001, 1011/0000000, 0111/1111111, each held 50 cycles -> Digits=16'hF813, Valid=1111, one Frame pulse; exactly 2+16 cycles from the last slot becoming stable to Valid[3].
- Glitch: Seg toggles every 10 cycles with SettleCycles=16 -> no capture, no Err, Digits unchanged.
- Illegal inputs: an=1100 held 30 cycles -> one Err pulse, Valid unchanged. Then an=1110 with Seg=0101010 -> one Err pulse and Valid[0]=0.
- Timeout: after a full frame, hold an=1111 for TimeoutCycles (set to 1000 in the bench) -> Stale=1 and Valid=0000 at cycle 1000. Next good slot -> Stale=0.
- Back-to-back frames: continuous scanning for 3 frames -> exactly 3 Frame pulses. A capture coinciding with a Frame pulse is counted toward the next frame.
